fft_input_reorder: RTL

//  Input stage directly upstream of the butterfly. Accepts one complex sample per cycle in natural order
//  and stores each frame at bit-reversed addresses in a two-bank ping-pong buffer. Emits first-stage

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_frame_ram.sv | 43 ++++
 rtl/fft_input_reorder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath.
//   - N_POINTS / LOG2_N : transform length and its log2
//   - DATA_WIDTH        : sample width (1 sign + 4 int + 5 frac, two's complement)
//   - cplx_t            : complex word packed as {im, re}
//   - bitrev()          : reverse the low nbits of an index
// The bit-reversal helper is shared by the input reorder stage, later stages
// and the bench reference model.
package fft_pkg;

    localparam int N_POINTS   = 8;
    localparam int LOG2_N     = 3;
    localparam int DATA_WIDTH = 10;
    localparam int CPLX_WIDTH = 2 * DATA_WIDTH;
    localparam int PAIR_W     = LOG2_N - 1;   // width of a pair index k

    typedef struct packed {
        logic [DATA_WIDTH-1:0] im;
        logic [DATA_WIDTH-1:0] re;
    } cplx_t;

    // Reverse the low nbits bits of idx; bits above nbits are ignored.
    function automatic int bitrev(input int idx, input int nbits);
        int r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < nbits) begin
                r = (r << 1) | ((idx >> b) & 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Two-bank frame store for the FFT input reorder stage.
//   i_clk              : clock, rising edge
//   i_wr_en            : write strobe
//   i_wr_bank          : bank written
//   i_wr_addr          : word address inside the bank (already bit-reversed)
//   i_wr_data          : complex word {im, re}
//   i_rd_bank          : bank read
//   i_rd_pair          : pair index k; reads addresses 2k and 2k+1
//   o_rd_even/o_rd_odd : combinational read data at 2k / 2k+1
// Storage has no reset: contents are only meaningful once a full frame has
// been written, and the full flags in the top level track that.
module fft_frame_ram
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [LOG2_N-1:0] i_wr_addr,
    input  cplx_t             i_wr_data,
    input  logic              i_rd_bank,
    input  logic [PAIR_W-1:0] i_rd_pair,
    output cplx_t             o_rd_even,
    output cplx_t             o_rd_odd
);

    cplx_t r_mem [2][N_POINTS];

    logic [LOG2_N-1:0] w_addr_even;
    logic [LOG2_N-1:0] w_addr_odd;

    assign w_addr_even = {i_rd_pair, 1'b0};
    assign w_addr_odd  = {i_rd_pair, 1'b1};

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_even = r_mem[i_rd_bank][w_addr_even];
    assign o_rd_odd  = r_mem[i_rd_bank][w_addr_odd];

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input reorder stage.
// Accepts one complex sample per cycle in natural order, stores each frame at
// bit-reversed addresses in a ping-pong buffer, and emits first-stage
// butterfly operand pairs (x[br(2k)], x[br(2k+1)]) for k = 0..N/2-1.
// Ports:
//   clk, rst                  : clock (rising edge), async active-low reset
//   in_valid/in_ready         : sample handshake
//   in_real/in_imag           : input sample
//   out_valid/out_ready       : operand pair handshake
//   out1_*/out2_*             : operands a / b for the butterfly
//   out_idx                   : pair index k
//   out_last                  : high on the final pair of a frame
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds its data stable while valid is high and ready
// is low; ready never depends on valid.
module fft_input_reorder
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out1_real,
    output logic [DATA_WIDTH-1:0] out1_imag,
    output logic [DATA_WIDTH-1:0] out2_real,
    output logic [DATA_WIDTH-1:0] out2_imag,
    output logic [PAIR_W-1:0]     out_idx,
    output logic                  out_last
);

    // Write side state
    logic [LOG2_N-1:0] r_wr_cnt;
    logic              r_wr_bank;
    // Read side state
    logic [PAIR_W-1:0] r_rd_pair;
    logic              r_rd_bank;
    // One flag per bank: set when a frame completes, cleared when its last pair is loaded
    logic [1:0]        r_full;
    logic [1:0]        w_full_nxt;

    // Output register
    logic              r_out_valid;
    cplx_t             r_out1;
    cplx_t             r_out2;
    logic [PAIR_W-1:0] r_out_idx;
    logic              r_out_last;

    logic              w_in_ready;
    logic              w_wr_fire;
    logic              w_wr_last;
    logic [LOG2_N-1:0] w_wr_addr;
    cplx_t             w_wr_data;
    logic              w_load;
    logic              w_rd_last;
    cplx_t             w_rd_even;
    cplx_t             w_rd_odd;

    // rst is folded in so in_ready reads 0 throughout reset and rises
    // combinationally on release.
    assign w_in_ready = rst & ~r_full[r_wr_bank];
    assign w_wr_fire  = in_valid & w_in_ready;
    assign w_wr_last  = w_wr_fire & (r_wr_cnt == LOG2_N'(N_POINTS - 1));
    assign w_wr_addr  = LOG2_N'(bitrev(int'(r_wr_cnt), LOG2_N));
    assign w_wr_data  = '{im: in_imag, re: in_real};

    assign w_load     = r_full[r_rd_bank] & (~r_out_valid | out_ready);
    assign w_rd_last  = w_load & (r_rd_pair == PAIR_W'(N_POINTS / 2 - 1));

    // Frame completion and bank release always touch different bits: the
    // writer only ever fills an empty bank, the reader only frees a full one.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    fft_frame_ram u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_fire),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_pair (r_rd_pair),
        .o_rd_even (w_rd_even),
        .o_rd_odd  (w_rd_odd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_pair <= '0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;   // wraps to 0 after N-1
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_load) begin
                r_rd_pair <= r_rd_pair + 1'b1; // wraps to 0 after N/2-1
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    // The bank is freed when its last pair is copied here, so the writer may
    // refill it while that pair still waits in the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out1      <= w_rd_even;
            r_out2      <= w_rd_odd;
            r_out_idx   <= r_rd_pair;
            r_out_last  <= w_rd_last;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out1_real = r_out1.re;
    assign out1_imag = r_out1.im;
    assign out2_real = r_out2.re;
    assign out2_imag = r_out2.im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
